// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU: opcodes, IR field positions
// and the fetch FSM state type.
package cpu16_pkg;

  localparam logic [3:0] OP_RLOGIC = 4'b0000;
  localparam logic [3:0] OP_RARITH = 4'b0001;
  localparam logic [3:0] OP_SHIFT  = 4'b0010;
  localparam logic [3:0] OP_ADDI   = 4'b1001;
  localparam logic [3:0] OP_SUBI   = 4'b1010;
  localparam logic [3:0] OP_SLTI   = 4'b1011;
  localparam logic [3:0] OP_LW     = 4'b1100;
  localparam logic [3:0] OP_SW     = 4'b1101;
  localparam logic [3:0] OP_BEQ    = 4'b1111;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 10;
  localparam int RT_MSB  = 9;
  localparam int RT_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 6;
  localparam int FN_MSB  = 1;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetchState_t;

  function automatic logic isLegalOp(
    input logic [3:0] op
  );
    return op inside {
      OP_RLOGIC, OP_RARITH, OP_SHIFT,
      OP_ADDI, OP_SUBI, OP_SLTI,
      OP_LW, OP_SW, OP_BEQ
    };
  endfunction

  function automatic logic [15:0] sext8(
    input logic [7:0] v
  );
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: instruction memory req/ack on one side,
// IR valid/ready plus decoded fields toward decode on the other.
interface instr_fetch_unit_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic        br_taken;
  logic [3:0]  opcode;
  logic [1:0]  rs;
  logic [1:0]  rt;
  logic [1:0]  rd;
  logic [1:0]  funct;
  logic [15:0] imm_sext;
  logic [15:0] pc_out;
  logic        illegal_op;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output ir_valid,
    input  ir_ready,
    input  br_taken,
    output opcode,
    output rs,
    output rt,
    output rd,
    output funct,
    output imm_sext,
    output pc_out,
    output illegal_op
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  ir_valid,
    output ir_ready,
    output br_taken,
    input  opcode,
    input  rs,
    input  rt,
    input  rd,
    input  funct,
    input  imm_sext,
    input  pc_out,
    input  illegal_op
  );

endinterface

// File: rtl/ifu_next_pc.sv
// Next-PC adder; BEQ redirect is present only with IFU_BRANCH_EN.
module ifu_next_pc
  import cpu16_pkg::*;
(
  input  logic [15:0] pcOut,
  input  logic [15:0] immSext,
  input  logic [3:0]  opcode,
  input  logic        brTaken,
  output logic [15:0] nextPc
);

  logic [15:0] seqPc;

  assign seqPc = pcOut + 16'd1;

`ifdef IFU_BRANCH_EN
  logic takeBr;

  assign takeBr = (opcode == OP_BEQ) && brTaken;

  always_comb begin
    nextPc = seqPc;
    if (takeBr)
      nextPc = seqPc + immSext;
  end
`else
  logic unusedBr;

  assign unusedBr = &{1'b0, brTaken, opcode, immSext};
  assign nextPc   = seqPc;
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, imem req/ack, IR and field decode.
// Optional BEQ redirect via IFU_BRANCH_EN.
module instr_fetch_unit
  import cpu16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  instr_fetch_unit_if.master bus
);

  fetchState_t state;
  logic [15:0] pc;
  logic [15:0] pcOut;
  logic [15:0] ir;
  logic [15:0] nextPc;
  logic [15:0] immSext;
  logic [3:0]  opc;
  logic        req;
  logic        valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RESET;
      pc    <= RESET_PC;
      pcOut <= RESET_PC;
      ir    <= 16'h0000;
      req   <= 1'b0;
      valid <= 1'b0;
    end else begin
      unique case (state)
        S_RESET: begin
          state <= S_FETCH;
          req   <= 1'b1;
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            ir    <= bus.imem_rdata;
            pcOut <= pc;
            req   <= 1'b0;
            valid <= 1'b1;
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.ir_ready) begin
            pc    <= nextPc;
            valid <= 1'b0;
            req   <= 1'b1;
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_RESET;
          req   <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign opc     = ir[OPC_MSB:OPC_LSB];
  assign immSext = sext8(ir[IMM_MSB:IMM_LSB]);

  ifu_next_pc u_nextPc (
    .pcOut   (pcOut),
    .immSext (immSext),
    .opcode  (opc),
    .brTaken (bus.br_taken),
    .nextPc  (nextPc)
  );

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc;
  assign bus.ir_valid   = valid;
  assign bus.opcode     = opc;
  assign bus.rs         = ir[RS_MSB:RS_LSB];
  assign bus.rt         = ir[RT_MSB:RT_LSB];
  assign bus.rd         = ir[RD_MSB:RD_LSB];
  assign bus.funct      = ir[FN_MSB:FN_LSB];
  assign bus.imm_sext   = immSext;
  assign bus.pc_out     = pcOut;
  // Informative only: the FSM never stalls on an unknown opcode.
  assign bus.illegal_op = (state == S_HOLD) && !isLegalOp(opc);

endmodule
